// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - Z80 bus signal bundle observed by the trap sequencer
interface trap_sequencer_if;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        m1_n;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;

  modport master (output addr, data, m1_n, mreq_n, iorq_n, rd_n, wr_n);
  modport slave  (input  addr, data, m1_n, mreq_n, iorq_n, rd_n, wr_n);
endinterface

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - Z80 I/O trap controller: NMI on port-window hit, ISR freeze until RETN
// Optional handler watchdog enabled by defining TRAP_TIMEOUT_EN.
module trap_sequencer #(
  parameter logic [7:0] TRAP_BASE  = 8'hA0,
  parameter logic [7:0] TRAP_MASK  = 8'hFE,
  parameter int         NMI_CYCLES = 4
`ifdef TRAP_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  trap_sequencer_if.slave  bus,
  input  logic             trap_en,
  input  logic             flag_clr,
  output logic             record_isr,
  output logic             nmi_n,
  output logic [7:0]       trap_port,
  output logic             trap_wr,
  output logic             in_handler,
  output logic             overrun_flag,
  output logic             timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_END,
    S_NMI,
    S_WAIT_VEC,
    S_HANDLER
  } state_t;

  localparam logic [3:0] NMI_LAST = 4'(NMI_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] nmi_cnt, nmi_cnt_nx;
  logic       nmi_n_nx;
  logic       capture;
  logic       overrun_set;
  logic       ed_seen, ed_seen_nx;
  logic [7:0] op;
  logic       m1_q;

  logic hit;
  logic m1_rise;
  logic opcode_fetch;
  logic vec_fetch;

`ifdef TRAP_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;
  logic        timeout_hit;
`endif

  // m1_n=1 keeps interrupt-acknowledge cycles (IORQ with M1) out of the window
  assign hit = !bus.iorq_n && bus.m1_n && (!bus.rd_n || !bus.wr_n) &&
               (((bus.addr[7:0] ^ TRAP_BASE) & TRAP_MASK) == 8'h00);
  assign m1_rise      = bus.m1_n && !m1_q;
  assign opcode_fetch = !bus.m1_n && !bus.mreq_n && !bus.rd_n;
  assign vec_fetch    = !bus.m1_n && !bus.mreq_n && (bus.addr == 16'h0066);

  always_comb begin
    state_nx    = state;
    nmi_cnt_nx  = nmi_cnt;
    nmi_n_nx    = nmi_n;
    capture     = 1'b0;
    overrun_set = 1'b0;
    ed_seen_nx  = ed_seen;
`ifdef TRAP_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (hit && trap_en) begin
          capture  = 1'b1;
          state_nx = S_WAIT_END;
        end
      end
      // The trapping access itself is still on the bus here, so no overrun
      S_WAIT_END: begin
        if (bus.iorq_n) begin
          state_nx   = S_NMI;
          nmi_n_nx   = 1'b0;
          nmi_cnt_nx = NMI_LAST;
        end
      end
      S_NMI: begin
        overrun_set = hit;
        if (nmi_cnt == 4'd0) begin
          nmi_n_nx = 1'b1;
          state_nx = S_WAIT_VEC;
        end else begin
          nmi_cnt_nx = nmi_cnt - 4'd1;
        end
      end
      S_WAIT_VEC: begin
        overrun_set = hit;
        if (vec_fetch) begin
          state_nx   = S_HANDLER;
          ed_seen_nx = 1'b0;
        end
      end
      S_HANDLER: begin
        overrun_set = hit;
        if (m1_rise) begin
          ed_seen_nx = (op == 8'hED);
          if (ed_seen && (op == 8'h45)) state_nx = S_IDLE;
        end
`ifdef TRAP_TIMEOUT_EN
        if (wd_cnt == TO_LAST) begin
          state_nx    = S_IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      nmi_cnt      <= 4'd0;
      nmi_n        <= 1'b1;
      record_isr   <= 1'b1;
      in_handler   <= 1'b0;
      trap_port    <= 8'h00;
      trap_wr      <= 1'b0;
      overrun_flag <= 1'b0;
      ed_seen      <= 1'b0;
      op           <= 8'h00;
      m1_q         <= 1'b1;
    end else begin
      state      <= state_nx;
      nmi_cnt    <= nmi_cnt_nx;
      nmi_n      <= nmi_n_nx;
      record_isr <= (state_nx == S_IDLE);
      in_handler <= (state_nx == S_HANDLER);
      ed_seen    <= ed_seen_nx;
      m1_q       <= bus.m1_n;
      if (capture) begin
        trap_port <= bus.addr[7:0];
        trap_wr   <= !bus.wr_n;
      end
      if (opcode_fetch) op <= bus.data;
      if (overrun_set)   overrun_flag <= 1'b1;
      else if (flag_clr) overrun_flag <= 1'b0;
    end
  end

`ifdef TRAP_TIMEOUT_EN
  // Held at zero outside the handler, so it restarts from zero on every entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt       <= 16'd0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == S_HANDLER) wd_cnt <= wd_cnt + 16'd1;
      else                    wd_cnt <= 16'd0;
      if (timeout_hit)   timeout_flag <= 1'b1;
      else if (flag_clr) timeout_flag <= 1'b0;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

endmodule
